// File: rtl/mlp_sample_sequencer.sv
// Serial feature loader and result capture around the combinational MLP regressor.
// Optional feat_last framing check is enabled by defining MLP_SEQ_FRAMECHK_EN.
module mlp_sample_sequencer #(
    parameter int WIDTH_A       = 4,
    parameter int NUM_A         = 11,
    parameter int OUTWIDTH      = 20,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     feat_valid,
    output logic                     feat_ready,
    input  logic [WIDTH_A-1:0]       feat_data,
    input  logic                     feat_last,
    output logic [NUM_A*WIDTH_A-1:0] inp,
    input  logic [OUTWIDTH-1:0]      cls_out,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [OUTWIDTH-1:0]      res_data,
    output logic                     err_frame
);

    localparam int IDXW = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int CNTW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUM_A - 1);
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t          state;
    logic [IDXW-1:0] idx;
    logic [CNTW-1:0] cnt;
    logic            xfer;
    logic            at_last;
    logic            frame_bad;

    // Ready is gated by reset so no word can slip in while the block is being cleared.
    assign feat_ready = (state == LOAD) && !rst;
    assign xfer       = feat_valid && feat_ready;
    assign at_last    = (idx == IDX_LAST);

`ifdef MLP_SEQ_FRAMECHK_EN
    assign frame_bad = (feat_last != at_last);
`else
    logic unused_feat_last;
    assign unused_feat_last = feat_last;
    assign frame_bad        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            idx       <= '0;
            cnt       <= '0;
            inp       <= '0;
            res_data  <= '0;
            res_valid <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            err_frame <= 1'b0;
            case (state)
                LOAD: begin
                    if (xfer) begin
                        inp[idx*WIDTH_A +: WIDTH_A] <= feat_data;
                        // A misframed word restarts the sample without launching it.
                        if (frame_bad) begin
                            idx       <= '0;
                            err_frame <= 1'b1;
                        end else if (at_last) begin
                            idx   <= '0;
                            cnt   <= CNT_INIT;
                            state <= SETTLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        res_data  <= cls_out;
                        res_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_sample_sequencer.sv
// Self-checking bench for mlp_sample_sequencer: cycle-level reference model plus directed
// literal checks. Honours MLP_SEQ_FRAMECHK_EN the same way the design does.
module tb_mlp_sample_sequencer;

    localparam int WA = 4;
    localparam int NA = 11;
    localparam int OW = 20;
    localparam int SC = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             feat_valid;
    logic             feat_ready;
    logic [WA-1:0]    feat_data;
    logic             feat_last;
    logic [NA*WA-1:0] inp;
    logic [OW-1:0]    cls_out;
    logic             res_valid;
    logic             res_ready;
    logic [OW-1:0]    res_data;
    logic             err_frame;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Classifier stub: low bits of the assembled input.
    assign cls_out = inp[OW-1:0];

    mlp_sample_sequencer #(
        .WIDTH_A(WA), .NUM_A(NA), .OUTWIDTH(OW), .SETTLE_CYCLES(SC)
    ) dut (
        .clk(clk), .rst(rst),
        .feat_valid(feat_valid), .feat_ready(feat_ready),
        .feat_data(feat_data), .feat_last(feat_last),
        .inp(inp), .cls_out(cls_out),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .err_frame(err_frame)
    );

    // Reference model: slots, count of words in the current sample, edges left until
    // capture, and whether a result is waiting for the consumer.
    logic [WA-1:0] m_slot [NA];
    int            m_count;
    int            m_wait;
    bit            m_hold;
    logic [OW-1:0] m_res;
    bit            m_err;
    bit            m_bad;
    bit            chk_en = 1'b0;
    int            cyc = 0;

    int xfers = 0;
    int rises = 0;
    int rise_cyc = 0;
    int errs_seen = 0;
    bit rv_q = 1'b0;
    int last_acc_cyc = 0;

    function automatic logic [NA*WA-1:0] model_inp();
        logic [NA*WA-1:0] v;
        v = '0;
        for (int i = 0; i < NA; i++) v[i*WA +: WA] = m_slot[i];
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        logic [NA*WA-1:0] snap;
        m_err = 1'b0;
        if (rst) begin
            chk_en = 1'b1;
            for (int i = 0; i < NA; i++) m_slot[i] = '0;
            m_count = 0;
            m_wait  = 0;
            m_hold  = 1'b0;
            m_res   = '0;
        end else if (m_hold) begin
            if (res_ready) m_hold = 1'b0;
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                snap   = model_inp();
                m_res  = snap[OW-1:0];
                m_hold = 1'b1;
            end
        end else if (feat_valid) begin
            m_slot[m_count] = feat_data;
`ifdef MLP_SEQ_FRAMECHK_EN
            m_bad = (feat_last == 1'b1) != (m_count == NA - 1);
`else
            m_bad = 1'b0;
`endif
            if (m_bad) begin
                m_err   = 1'b1;
                m_count = 0;
            end else if (m_count == NA - 1) begin
                m_count = 0;
                m_wait  = SC;
            end else begin
                m_count++;
            end
        end
    end

    // Compare process plus event counters used by the directed checks.
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("feat_ready", {63'd0, feat_ready}, {63'd0, (!rst && !m_hold && m_wait == 0)});
            checkOutput("res_valid", {63'd0, res_valid}, {63'd0, m_hold});
            checkOutput("res_data", 64'(res_data), 64'(m_res));
            checkOutput("inp", 64'(inp), 64'(model_inp()));
            checkOutput("err_frame", {63'd0, err_frame}, {63'd0, m_err});
        end
        if (feat_valid && feat_ready) xfers++;
        if (res_valid && !rv_q) begin
            rises++;
            rise_cyc = cyc;
        end
        rv_q = res_valid;
        if (err_frame) errs_seen++;
    end

    task automatic applyStimulus(input logic [WA-1:0] d, input logic last, input int gap);
        int n;
        bit ok;
        n = 0;
        ok = 1'b0;
        feat_valid = 1'b1;
        feat_data  = d;
        feat_last  = last;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = feat_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_timeout: got no handshake, expected one within 200 cycles");
        end
        last_acc_cyc = cyc;
        feat_valid = 1'b0;
        feat_last  = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendSample(input int start, input int step, input int gap);
        for (int i = 0; i < NA; i++)
            applyStimulus(WA'(start + i * step), (i == NA - 1), gap);
    endtask

    task automatic waitResult();
        int n;
        n = 0;
        while (!res_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL result_timeout: got res_valid=0, expected 1 within 100 cycles");
        end
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int x0;
        int e0;
        int r0;
        rst = 1'b1;
        feat_valid = 1'b0;
        feat_data = '0;
        feat_last = 1'b0;
        res_ready = 1'b0;

        idle(2);
        checkOutput("rst_inp", 64'(inp), 64'd0);
        checkOutput("rst_res_valid", {63'd0, res_valid}, 64'd0);
        checkOutput("rst_res_data", 64'(res_data), 64'd0);
        checkOutput("rst_err_frame", {63'd0, err_frame}, 64'd0);
        checkOutput("rst_feat_ready", {63'd0, feat_ready}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("ready_after_rst", {63'd0, feat_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Single sample 1..11, result held under backpressure.
        sendSample(1, 1, 0);
        waitResult();
        checkOutput("latency_single", 64'(rise_cyc - last_acc_cyc), 64'd8);
        checkOutput("inp_single", 64'(inp), 64'h0BA987654321);
        checkOutput("res_single", 64'(res_data), 64'h54321);
        feat_valid = 1'b1;
        feat_data  = 4'hF;
        idle(20);
        feat_valid = 1'b0;
        checkOutput("bp_res_valid", {63'd0, res_valid}, 64'd1);
        checkOutput("bp_res_data", 64'(res_data), 64'h54321);
        checkOutput("bp_feat_ready", {63'd0, feat_ready}, 64'd0);
        checkOutput("bp_inp", 64'(inp), 64'h0BA987654321);
        res_ready = 1'b1;
        idle(1);
        res_ready = 1'b0;
        checkOutput("release_res_valid", {63'd0, res_valid}, 64'd0);
        checkOutput("release_feat_ready", {63'd0, feat_ready}, 64'd1);

        // Gapped input 11..1, with words offered during SETTLE and HOLD.
        x0 = xfers;
        sendSample(11, -1, 1);
        feat_valid = 1'b1;
        feat_data  = 4'h0;
        idle(SC + 3);
        feat_valid = 1'b0;
        checkOutput("gap_transfers", 64'(xfers - x0), 64'd11);
        checkOutput("gap_inp", 64'(inp), 64'h0123456789AB);
        checkOutput("gap_res", 64'(res_data), 64'h789AB);
        checkOutput("gap_res_valid", {63'd0, res_valid}, 64'd1);
        res_ready = 1'b1;
        idle(1);

        // Framing: early feat_last on the 5th word, then a full 0..10 sample.
        e0 = errs_seen;
        r0 = rises;
        for (int i = 0; i < 5; i++) applyStimulus(4'hC, (i == 4), 0);
        sendSample(0, 1, 0);
        idle(20);
        checkOutput("frame_results", 64'(rises - r0), 64'd1);
`ifdef MLP_SEQ_FRAMECHK_EN
        checkOutput("frame_err_pulses", 64'(errs_seen - e0), 64'd1);
        checkOutput("frame_res", 64'(res_data), 64'h43210);
`else
        checkOutput("frame_err_pulses", 64'(errs_seen - e0), 64'd0);
        checkOutput("frame_res", 64'(res_data), 64'hCCCCC);
`endif

        // Reset in the middle of SETTLE discards the pending result.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sendSample(7, 0, 0);
        idle(2);
        r0 = rises;
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        checkOutput("midrst_inp", 64'(inp), 64'd0);
        checkOutput("midrst_res_valid", {63'd0, res_valid}, 64'd0);
        idle(15);
        checkOutput("midrst_no_result", 64'(rises - r0), 64'd0);
        sendSample(1, 1, 0);
        waitResult();
        checkOutput("latency_after_rst", 64'(rise_cyc - last_acc_cyc), 64'd8);
        checkOutput("res_after_rst", 64'(res_data), 64'h54321);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
